// File: rtl/shift_reg_pkg.sv
// Shared op codes and sequencer state encoding for the universal shift register.
package shift_reg_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROTL = 3'b100;
  localparam logic [2:0] OP_ROTR = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_reg_next.sv
// Combinational next-value unit: one-position shift/rotate of q selected by op.
// Parallel load is handled by the owner of the register, so load and both hold
// codes simply pass q through here.
module shift_reg_next
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [2:0]       i_op,
  input  logic             i_sin_l,
  input  logic             i_sin_r,
  output logic [WIDTH-1:0] o_qNext
);

  // Select the shifted/rotated form of q, defaulting to an unchanged value
  always_comb begin
    o_qNext = i_q;
    case (i_op)
      OP_SHL:  o_qNext = {i_q[WIDTH-2:0], i_sin_l};
      OP_SHR:  o_qNext = {i_sin_r, i_q[WIDTH-1:1]};
      OP_ROTL: o_qNext = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
      OP_ROTR: o_qNext = {i_q[0], i_q[WIDTH-1:1]};
      OP_ASR:  o_qNext = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
      default: o_qNext = i_q;
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal register with op-code load/shift/rotate and a serial-shift sequencer
// that loads a word on start and then shifts it once per cycle for a set count.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sin_l,
  input  logic             i_sin_r,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_amt,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout_l,
  output logic             o_sout_r,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_qNext;
  logic [WIDTH-1:0] w_shifted;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic [CNT_W-1:0] w_amtSat;
  logic             r_dir;
  logic             w_dirNext;
  logic             r_done;
  logic             w_doneNext;
  logic [2:0]       w_nextOp;

  // While running, the shared unit is forced to a plain shift in the latched direction
  always_comb begin
    w_nextOp = i_op;
    if (r_state == ST_RUN) begin
      w_nextOp = r_dir ? OP_SHR : OP_SHL;
    end
  end

  // Counts beyond the register width behave like a full-width shift
  always_comb begin
    w_amtSat = (i_amt > MAX_CNT) ? MAX_CNT : i_amt;
  end

  shift_reg_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .i_q     (r_q),
    .i_op    (w_nextOp),
    .i_sin_l (i_sin_l),
    .i_sin_r (i_sin_r),
    .o_qNext (w_shifted)
  );

  // Next-state logic: clear beats a running sequence, which beats start, which beats the op path
  always_comb begin
    w_stateNext = r_state;
    w_qNext     = r_q;
    w_cntNext   = r_cnt;
    w_dirNext   = r_dir;
    w_doneNext  = 1'b0;
    if (i_clr) begin
      w_stateNext = ST_IDLE;
      w_qNext     = '0;
      w_cntNext   = '0;
    end else if (r_state == ST_RUN) begin
      w_qNext   = w_shifted;
      w_cntNext = r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) begin
        w_stateNext = ST_IDLE;
        w_doneNext  = 1'b1;
      end
    end else if (i_start) begin
      w_qNext = i_d;
      if (w_amtSat != '0) begin
        w_cntNext   = w_amtSat;
        w_dirNext   = i_dir;
        w_stateNext = ST_RUN;
      end else begin
        w_doneNext = 1'b1;
      end
    end else if (i_en) begin
      w_qNext = (i_op == OP_LOAD) ? i_d : w_shifted;
    end
  end

  // State, data, count and done registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_q     <= RST_VAL;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_q     <= w_qNext;
      r_cnt   <= w_cntNext;
      r_dir   <= w_dirNext;
      r_done  <= w_doneNext;
    end
  end

  assign o_q      = r_q;
  assign o_sout_l = r_q[WIDTH-1];
  assign o_sout_r = r_q[0];
  assign o_busy   = (r_state == ST_RUN);
  assign o_done   = r_done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: each stimulus cycle pushes its expected
// outputs to a scoreboard queue, which is popped and compared after the clock edge.
module tb_shift_reg_univ;

  localparam logic [2:0] OpHold = 3'b000;
  localparam logic [2:0] OpLoad = 3'b001;
  localparam logic [2:0] OpShl  = 3'b010;
  localparam logic [2:0] OpShr  = 3'b011;
  localparam logic [2:0] OpRotl = 3'b100;
  localparam logic [2:0] OpRotr = 3'b101;
  localparam logic [2:0] OpAsr  = 3'b110;
  localparam logic [2:0] OpHld2 = 3'b111;

  typedef struct packed {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } expect_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       en;
  logic [2:0] op;
  logic [7:0] d;
  logic       sinL;
  logic       sinR;
  logic       start;
  logic [3:0] amt;
  logic       dir;
  logic [7:0] q;
  logic       soutL;
  logic       soutR;
  logic       busy;
  logic       done;

  int errCount   = 0;
  int checkCount = 0;

  expect_t sbQueue[$];
  string   tagQueue[$];

  shift_reg_univ #(
    .WIDTH   (8),
    .RST_VAL (8'hA5)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clr    (clr),
    .i_en     (en),
    .i_op     (op),
    .i_d      (d),
    .i_sin_l  (sinL),
    .i_sin_r  (sinR),
    .i_start  (start),
    .i_amt    (amt),
    .i_dir    (dir),
    .o_q      (q),
    .o_sout_l (soutL),
    .o_sout_r (soutR),
    .o_busy   (busy),
    .o_done   (done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, then score the DUT after the edge
  task automatic applyStimulus(input string tag, input logic iClr, input logic iEn,
                               input logic [2:0] iOp, input logic [7:0] iD,
                               input logic iSinL, input logic iSinR, input logic iStart,
                               input logic [3:0] iAmt, input logic iDir,
                               input logic [7:0] expQ, input logic expBusy, input logic expDone);
    expect_t e;
    expect_t got;
    string   t;
    clr   = iClr;
    en    = iEn;
    op    = iOp;
    d     = iD;
    sinL  = iSinL;
    sinR  = iSinR;
    start = iStart;
    amt   = iAmt;
    dir   = iDir;
    e.q    = expQ;
    e.busy = expBusy;
    e.done = expDone;
    sbQueue.push_back(e);
    tagQueue.push_back(tag);
    @(posedge clk);
    #1;
    got = sbQueue.pop_front();
    t   = tagQueue.pop_front();
    checkOutput({t, ".q"}, 32'(q), 32'(got.q));
    checkOutput({t, ".busy"}, 32'(busy), 32'(got.busy));
    checkOutput({t, ".done"}, 32'(done), 32'(got.done));
    checkOutput({t, ".sout_l"}, 32'(soutL), 32'(got.q[7]));
    checkOutput({t, ".sout_r"}, 32'(soutR), 32'(got.q[0]));
  endtask

  // Op-path cycle with en=1 and no sequencer activity
  task automatic opStep(input string tag, input logic [2:0] iOp, input logic [7:0] iD,
                        input logic iSinL, input logic iSinR, input logic [7:0] expQ);
    applyStimulus(tag, 1'b0, 1'b1, iOp, iD, iSinL, iSinR, 1'b0, 4'd0, 1'b0, expQ, 1'b0, 1'b0);
  endtask

  // Quiet cycle: nothing enabled, only the sequencer may move
  task automatic idleStep(input string tag, input logic iSinL, input logic iSinR,
                          input logic [7:0] expQ, input logic expBusy, input logic expDone);
    applyStimulus(tag, 1'b0, 1'b0, OpHold, 8'h00, iSinL, iSinR, 1'b0, 4'd0, 1'b0, expQ, expBusy, expDone);
  endtask

  initial begin
    logic [7:0] ones;
    rst   = 1'b1;
    clr   = 1'b0;
    en    = 1'b0;
    op    = OpHold;
    d     = 8'h00;
    sinL  = 1'b0;
    sinR  = 1'b0;
    start = 1'b0;
    amt   = 4'd0;
    dir   = 1'b0;

    #12;
    checkOutput("reset.q", 32'(q), 32'h A5);
    checkOutput("reset.busy", 32'(busy), 32'h0);
    checkOutput("reset.done", 32'(done), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load, rotate, arithmetic shift
    opStep("load81", OpLoad, 8'h81, 1'b0, 1'b0, 8'h81);
    opStep("rotl", OpRotl, 8'h00, 1'b0, 1'b0, 8'h03);
    opStep("rotr1", OpRotr, 8'h00, 1'b0, 1'b0, 8'h81);
    opStep("rotr2", OpRotr, 8'h00, 1'b0, 1'b0, 8'hC0);
    opStep("load80", OpLoad, 8'h80, 1'b0, 1'b0, 8'h80);
    opStep("asr", OpAsr, 8'h00, 1'b0, 1'b0, 8'hC0);

    // Shift ones in from the LSB side, then check en=0 holds
    opStep("load00", OpLoad, 8'h00, 1'b0, 1'b0, 8'h00);
    opStep("shl1", OpShl, 8'h00, 1'b1, 1'b0, 8'h01);
    opStep("shl2", OpShl, 8'h00, 1'b1, 1'b0, 8'h03);
    opStep("shl3", OpShl, 8'h00, 1'b1, 1'b0, 8'h07);
    opStep("shl4", OpShl, 8'h00, 1'b1, 1'b0, 8'h0F);
    applyStimulus("en0", 1'b0, 1'b0, OpShl, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h0F, 1'b0, 1'b0);
    opStep("shr", OpShr, 8'h00, 1'b0, 1'b1, 8'h87);
    opStep("hold111", OpHld2, 8'hFF, 1'b1, 1'b1, 8'h87);
    opStep("hold000", OpHold, 8'hFF, 1'b1, 1'b1, 8'h87);

    // Sequence F0 right by 3; a second start while busy must be ignored
    applyStimulus("seq.load", 1'b0, 1'b0, OpHold, 8'hF0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 8'hF0, 1'b1, 1'b0);
    applyStimulus("seq.s1", 1'b0, 1'b1, OpLoad, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 8'h78, 1'b1, 1'b0);
    idleStep("seq.s2", 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0);
    idleStep("seq.s3", 1'b0, 1'b0, 8'h1E, 1'b0, 1'b1);
    idleStep("seq.after", 1'b0, 1'b0, 8'h1E, 1'b0, 1'b0);

    // Zero-length sequence: load only, done on the next cycle
    applyStimulus("amt0", 1'b0, 1'b0, OpHold, 8'h5A, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 8'h5A, 1'b0, 1'b1);
    idleStep("amt0.after", 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);

    // Oversized count saturates to 8 shifts; op path is blocked while busy
    applyStimulus("sat.load", 1'b0, 1'b0, OpHold, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 8'hFF, 1'b1, 1'b0);
    ones = 8'hFF;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus("sat.shift", 1'b0, 1'b1, OpLoad, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0,
                    8'(ones << k), (k < 8), (k == 8));
    end
    idleStep("sat.after", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Clear at the second shift aborts with no done pulse
    applyStimulus("clr.load", 1'b0, 1'b0, OpHold, 8'hF0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b1, 8'hF0, 1'b1, 1'b0);
    idleStep("clr.s1", 1'b0, 1'b1, 8'hF8, 1'b1, 1'b0);
    applyStimulus("clr.abort", 1'b1, 1'b0, OpHold, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    idleStep("clr.after", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // Clear and start together: clear wins
    applyStimulus("clrStart", 1'b1, 1'b0, OpHold, 8'hAA, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 8'h00, 1'b0, 1'b0);
    idleStep("clrStart.after", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a sequence
    applyStimulus("rst.load", 1'b0, 1'b0, OpHold, 8'h3C, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 8'h3C, 1'b1, 1'b0);
    idleStep("rst.s1", 1'b0, 1'b0, 8'h78, 1'b1, 1'b0);
    rst = 1'b1;
    #2;
    checkOutput("rstMid.q", 32'(q), 32'h A5);
    checkOutput("rstMid.busy", 32'(busy), 32'h0);
    checkOutput("rstMid.done", 32'(done), 32'h0);
    #1;
    rst = 1'b0;
    idleStep("rst.after", 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal register: a WIDTH-bit register with asynchronous active-high reset and synchronous clear, enable and op-code-selected load/shift/rotate. It adds a serial-shift sequencer: one start pulse loads a word and then shifts it one bit per cycle for a programmed count. It replaces single-bit D flip-flops wherever the design needs registers, serial converters or timed shifting.

## Interface
- WIDTH, 8: register width in bits, ≥2.
- RST_VAL, 0: value of q after rst, WIDTH bits.
- CNT_W, $clog2(WIDTH+1): width of the sequencer shift count.

- clk  in  1  rising-edge clock.
- rst  in  1  reset; clock and reset are one clock, reset asynchronous, active-high.
- clr  in  1  synchronous clear; q <= 0.
- en  in  1  enables the op-code path; ignored while busy.
- op  in  3  operation: 000 hold, 001 load, 010 shl, 011 shr, 100 rotl, 101 rotr, 110 asr, 111 hold.
- d  in  WIDTH  parallel load data.
- sin_l  in  1  serial in at LSB for shl.
- sin_r  in  1  serial in at MSB for shr.
- start  in  1  sequencer start pulse; ignored while busy.
- amt  in  CNT_W  sequencer shift count, 0..WIDTH.
- dir  in  1  sequencer direction: 0 = shl, 1 = shr; serial-in is taken from sin_l or sin_r.
- q  out  WIDTH  register contents.
- sout_l  out  1  q[WIDTH-1], combinational from q.
- sout_r  out  1  q[0], combinational from q.
- busy  out  1  sequencer running.
- done  out  1  one-cycle pulse when a sequence completes.

## Operation
- Reset: while rst is high, q = RST_VAL, busy = 0, done = 0, the state is IDLE, and the internal count is 0. This holds regardless of clk.
- Priority at each rising clk edge: clr > sequencer > start > en/op > hold.
- clr: q <= 0, state → IDLE, busy <= 0, done <= 0. clr aborts a running sequence and does not pulse done.
- Op path, active in IDLE with en=1 and start=0:
  - load: q <= d.
  - shl: q <= {q[W-2:0], sin_l}.
  - shr: q <= {sin_r, q[W-1:1]}.
  - rotl and rotr: circular shift by 1.
  - asr: q <= {q[W-1], q[W-1:1]}.
  - 000 and 111: hold.
- en=0 in IDLE holds q.
- Sequencer FSM, states IDLE and RUN:
  - IDLE, start=1, amt>0: q <= d, count <= amt, dir is latched, → RUN, busy <= 1.
  - IDLE, start=1, amt=0: q <= d, stay IDLE, done <= 1 the next cycle.
  - RUN: each cycle, shift once in the latched direction using the live sin_l or sin_r, then count <= count−1. The cycle on which count reaches 1 performs the last shift; then → IDLE, busy <= 0, done <= 1.
  - amt > WIDTH is saturated to WIDTH; after WIDTH shifts q holds only serial-in bits.
- done is high for exactly one cycle and low otherwise.

## Timing
- Load, shift and rotate take effect on q at the same rising edge: 1-cycle latency.
- Sequence with amt=N: load at edge 0, shifts at edges 1..N. busy is high from after edge 0 through edge N. done is high for the cycle after edge N.
- start during busy is ignored with no queueing. start is accepted on the same edge busy falls only if busy was already 0 when the edge was sampled; busy is registered, so no overlap occurs.
- Asynchronous rst mid-sequence returns everything to reset values immediately, with no done pulse.
- sout_l and sout_r have zero latency relative to q.

## Structure
- Package shift_reg_pkg: the op-code localparams (OP_HOLD, OP_LOAD, OP_SHL, OP_SHR, OP_ROTL, OP_ROTR, OP_ASR) and the state encoding (ST_IDLE, ST_RUN).
- Sub-module shift_reg_next: a combinational next-value function (q, op, sin_l, sin_r → q_next). It is shared by the op path and the sequencer, which drives it with op = OP_SHL or OP_SHR.
- Top level holds the q register, the count register and the FSM.

## Test plan
- Assert rst asynchronously mid-cycle with RST_VAL=8'hA5 → q=A5, busy=0, done=0 before the next clk edge.
- Load 8'h81, then rotl → 03, rotr twice → C0. Then asr on 8'h80 → C0.
- Apply shl four times with sin_l=1 from 00 → 0F. Drop en=0 with op=shl → q stays 0F.
- start with d=8'hF0, amt=3, dir=1, sin_r=0 → busy for 3 cycles, q goes F0→78→3C→1E, then done pulses once. start applied during busy has no effect.
- start with amt=0 and d=5A → q=5A, busy stays 0, done pulses next cycle.
- clr during RUN at the 2nd shift → q=00, IDLE, no done pulse. Simultaneous clr and start → clr wins.
